// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - EX stage to divider request/result bundle
interface ex_div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  // EX stage side: issues the request, consumes the result
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div.sv
// rtl/ex_div.sv - 32-bit iterative restoring divider (DIV/DIVU) for the EX stage
module ex_div (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  div
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [64:0] work_q;
  logic [31:0] divisor_q;
  logic        signed_q;
  logic        neg1_q;
  logic        neg2_q;
  logic [63:0] result_q;
  logic        ready_q;

  logic [31:0] abs1_d;
  logic [31:0] abs2_d;
  logic [32:0] trial_d;
  logic [64:0] work_step_d;
  logic [31:0] quo_raw;
  logic [31:0] rem_raw;
  logic [31:0] quo_fix_d;
  logic [31:0] rem_fix_d;

  // Operand magnitudes, one restoring step, and final sign correction
  always_comb begin
    abs1_d = (div.signed_div_i && div.opdata1_i[31]) ? (~div.opdata1_i + 32'd1) : div.opdata1_i;
    abs2_d = (div.signed_div_i && div.opdata2_i[31]) ? (~div.opdata2_i + 32'd1) : div.opdata2_i;

    // Borrow out of the 33-bit trial means the divisor did not fit
    trial_d = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    if (trial_d[32]) begin
      work_step_d = {work_q[63:0], 1'b0};
    end else begin
      work_step_d = {trial_d[31:0], work_q[31:0], 1'b1};
    end

    // After 32 steps the quotient sits in the low word, remainder above bit 32
    quo_raw   = work_q[31:0];
    rem_raw   = work_q[64:33];
    quo_fix_d = (signed_q && (neg1_q ^ neg2_q)) ? (~quo_raw + 32'd1) : quo_raw;
    rem_fix_d = (signed_q && neg1_q) ? (~rem_raw + 32'd1) : rem_raw;
  end

  // Divider FSM with iteration datapath and registered result/ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          result_q <= 64'd0;
          ready_q  <= 1'b0;
          if (div.start_i && !div.annul_i) begin
            if (div.opdata2_i == 32'd0) begin
              state_q <= BYZERO;
            end else begin
              state_q   <= ON;
              cnt_q     <= 6'd0;
              work_q    <= {32'd0, abs1_d, 1'b0};
              divisor_q <= abs2_d;
              signed_q  <= div.signed_div_i;
              neg1_q    <= div.opdata1_i[31];
              neg2_q    <= div.opdata2_i[31];
            end
          end
        end
        BYZERO: begin
          result_q <= 64'd0;
          if (div.annul_i) begin
            state_q <= FREE;
            ready_q <= 1'b0;
          end else begin
            state_q <= END;
            ready_q <= 1'b1;
          end
        end
        ON: begin
          if (div.annul_i) begin
            state_q  <= FREE;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
          end else if (cnt_q != 6'd32) begin
            work_q <= work_step_d;
            cnt_q  <= cnt_q + 6'd1;
          end else begin
            result_q <= {rem_fix_d, quo_fix_d};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        END: begin
          // Hold the result until EX releases its request; flushes are ignored here
          if (!div.start_i) begin
            state_q  <= FREE;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign div.result_o = result_q;
  assign div.ready_o  = ready_q;

endmodule
